// File: rtl/crc_frame_checker.sv
// Collects 6-byte frames (4 payload + 2 CRC bytes), hands the payload to an external CRC
// engine, and reports the checked word with CRC, gap and timeout error status.
module crc_frame_checker #(
    parameter int unsigned BYTE_GAP_MAX = 1000,
    parameter int unsigned CRC_WAIT_MAX = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        crc_start,
    output logic [31:0] crc_data,
    input  logic [16:0] crc_result,
    input  logic        crc_done,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        crc_err,
    output logic        gap_err,
    output logic        timeout_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam int unsigned GapW  = $clog2(BYTE_GAP_MAX + 1);
    localparam int unsigned WaitW = $clog2(CRC_WAIT_MAX + 1);

    typedef enum logic [1:0] {StCollect, StStart, StWait, StReport} state_e;

    state_e            state_q, state_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0]       payload_q, payload_d;
    logic [15:0]       crc_exp_q, crc_exp_d;
    logic              crc_err_q, crc_err_d;
    logic [15:0]       frames_ok_q, frames_ok_d;
    logic [15:0]       frames_bad_q, frames_bad_d;
    logic              accept;
    logic              unused_crc_msb;

    assign unused_crc_msb = crc_result[16];
    assign accept         = in_valid && (state_q == StCollect);
    assign frames_ok      = frames_ok_q;
    assign frames_bad     = frames_bad_q;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        payload_d    = payload_q;
        crc_exp_d    = crc_exp_q;
        crc_err_d    = crc_err_q;
        frames_ok_d  = frames_ok_q;
        frames_bad_d = frames_bad_q;
        in_ready     = 1'b0;
        crc_start    = 1'b0;
        crc_data     = 32'h0;
        word_out     = 32'h0;
        word_valid   = 1'b0;
        crc_err      = 1'b0;
        gap_err      = 1'b0;
        timeout_err  = 1'b0;

        unique case (state_q)
            StCollect: begin
                in_ready = 1'b1;
                if (accept) begin
                    gap_cnt_d = '0;
                    if (byte_cnt_q < 3'd4) begin
                        payload_d = {payload_q[23:0], in_byte};
                    end else begin
                        crc_exp_d = {crc_exp_q[7:0], in_byte};
                    end
                    if (byte_cnt_q == 3'd5) begin
                        byte_cnt_d = 3'd0;
                        state_d    = StStart;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end else if (byte_cnt_q != 3'd0) begin
                    // An accepted byte in the limit cycle takes the branch above and survives.
                    if (gap_cnt_q == GapW'(BYTE_GAP_MAX - 1)) begin
                        gap_err    = 1'b1;
                        byte_cnt_d = 3'd0;
                        gap_cnt_d  = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GapW'(1);
                    end
                end
            end
            StStart: begin
                crc_start  = 1'b1;
                crc_data   = payload_q;
                wait_cnt_d = WaitW'(1);
                state_d    = StWait;
            end
            StWait: begin
                crc_data = payload_q;
                // The first WAIT cycle ignores done so a stale completion cannot be taken.
                if (wait_cnt_q != WaitW'(1) && crc_done) begin
                    crc_err_d = (crc_result[15:0] != crc_exp_q);
                    state_d   = StReport;
                end else if (wait_cnt_q == WaitW'(CRC_WAIT_MAX)) begin
                    timeout_err  = 1'b1;
                    frames_bad_d = (frames_bad_q == 16'hFFFF) ? frames_bad_q : frames_bad_q + 16'd1;
                    state_d      = StCollect;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StReport: begin
                word_valid = 1'b1;
                word_out   = payload_q;
                crc_err    = crc_err_q;
                if (crc_err_q) begin
                    frames_bad_d = (frames_bad_q == 16'hFFFF) ? frames_bad_q : frames_bad_q + 16'd1;
                end else begin
                    frames_ok_d = (frames_ok_q == 16'hFFFF) ? frames_ok_q : frames_ok_q + 16'd1;
                end
                state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StCollect;
            byte_cnt_q   <= 3'd0;
            gap_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            payload_q    <= 32'h0;
            crc_exp_q    <= 16'h0;
            crc_err_q    <= 1'b0;
            frames_ok_q  <= 16'h0;
            frames_bad_q <= 16'h0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            payload_q    <= payload_d;
            crc_exp_q    <= crc_exp_d;
            crc_err_q    <= crc_err_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

endmodule

// File: doc/crc_frame_checker.md
CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

Interface
REQ-001 SHALL have parameter BYTE_GAP_MAX, default 1000, meaning the maximum idle cycles allowed between bytes of one frame.
REQ-002 SHALL have parameter CRC_WAIT_MAX, default 200, meaning the maximum cycles to wait for crc_done.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port in_byte, input, 8, received byte.
REQ-006 SHALL have port in_valid, input, 1, in_byte valid.
REQ-007 SHALL have port in_ready, output, 1, byte accepted when in_valid && in_ready.
REQ-008 SHALL have port crc_start, output, 1, start pulse to the CRC engine.
REQ-009 SHALL have port crc_data, output, 32, payload word to the CRC engine.
REQ-010 SHALL have port crc_result, input, 17, CRC engine remainder; only bits [15:0] are used.
REQ-011 SHALL have port crc_done, input, 1, CRC engine completion.
REQ-012 SHALL have port word_out, output, 32, checked payload.
REQ-013 SHALL have port word_valid, output, 1, one-cycle pulse; word_out and crc_err are valid.
REQ-014 SHALL have port crc_err, output, 1, CRC mismatch flag, qualified by word_valid.
REQ-015 SHALL have port gap_err, output, 1, one-cycle pulse when a partial frame is discarded.
REQ-016 SHALL have port timeout_err, output, 1, one-cycle pulse when crc_done does not arrive.
REQ-017 SHALL have port frames_ok, output, 16, saturating count of good frames.
REQ-018 SHALL have port frames_bad, output, 16, saturating count of CRC-error plus timeout frames.

Function
REQ-019 SHALL define a frame as 6 bytes: payload bytes B0..B3 followed by CRC bytes C_hi, C_lo.
REQ-020 SHALL pack the payload big-endian: B0 into bits [31:24], through B3 into bits [7:0].
REQ-021 SHALL implement states COLLECT, START, WAIT and REPORT.
REQ-022 In COLLECT, in_ready SHALL be 1; each accepted byte increments a byte count 0..5.
REQ-023 Acceptance of the 6th byte SHALL move the state to START on the next cycle.
REQ-024 In START, the block SHALL drive crc_start=1 for exactly one cycle, then move to WAIT.
REQ-025 crc_data SHALL hold the packed payload from START until the block leaves WAIT; it is 0 otherwise.
REQ-026 In START, WAIT and REPORT, in_ready SHALL be 0.
REQ-027 WAIT SHALL ignore crc_done in its first cycle, to guard against a stale done.
REQ-028 From the second WAIT cycle, crc_done=1 SHALL move the state to REPORT.
REQ-029 On entry to REPORT, the block SHALL latch crc_err = (crc_result[15:0] != {C_hi,C_lo}).
REQ-030 REPORT SHALL last one cycle, with word_valid=1 and word_out equal to the payload.
REQ-031 After REPORT, the state SHALL return to COLLECT with the byte count at 0.
REQ-032 Latency: with the 6th byte accepted at cycle N, crc_start=1 at N+1; if crc_done is first accepted at cycle M, word_valid=1 at M+1.
REQ-033 A WAIT counter SHALL reach CRC_WAIT_MAX without crc_done -> timeout_err pulse for one cycle, frames_bad+1, return to COLLECT, word_valid not asserted.
REQ-034 If crc_done=1 in the same cycle the WAIT counter reaches CRC_WAIT_MAX, done SHALL win: REPORT, no timeout.
REQ-035 In COLLECT with byte count >0, a gap counter SHALL count cycles with no accepted byte and clear on each accepted byte.
REQ-036 The gap counter reaching BYTE_GAP_MAX SHALL cause a gap_err pulse, byte count cleared, and frames_bad unchanged.
REQ-037 A byte accepted in the same cycle the gap limit is reached SHALL be kept, with no gap_err.
REQ-038 word_valid with crc_err=0 SHALL increment frames_ok; with crc_err=1 it SHALL increment frames_bad.
REQ-039 Both counters SHALL saturate at 0xFFFF.
REQ-040 crc_result[16] SHALL be ignored.

Reset
REQ-041 rst=1 at any clock edge SHALL force state COLLECT and clear the byte, gap and WAIT counters.
REQ-042 rst=1 SHALL clear frames_ok and frames_bad.
REQ-043 rst=1 SHALL force the output reset values: in_ready=1; crc_start, word_valid, crc_err, gap_err, timeout_err = 0; crc_data, word_out = 0.
REQ-044 rst asserted mid-frame or in WAIT SHALL discard the frame with no error pulses; a crc_done arriving after reset SHALL be ignored.

Verification
REQ-045 Bytes 12 34 56 78 then the engine-model CRC bytes -> crc_start pulse with crc_data=0x12345678; word_valid with word_out=0x12345678, crc_err=0; frames_ok=1.
REQ-046 Engine stub returning crc_result=0x0ABCD with CRC bytes AB CD -> crc_err=0; same stub with bytes AB CE -> crc_err=1, frames_bad=1.
REQ-047 Stub never asserts done -> timeout_err at WAIT cycle 200, no word_valid, frames_bad=1, in_ready=1 on the next cycle.
REQ-048 3 bytes then 1000 idle cycles -> gap_err pulse; a following full 6-byte frame checks correctly.
REQ-049 rst asserted 3 cycles into WAIT, then the stub asserts done -> no word_valid, counters 0, in_ready=1.
REQ-050 frames_ok preloaded near 0xFFFF by 0xFFFF good frames (or force) plus one more good frame -> frames_ok stays 0xFFFF.
